// File: rtl/gac_rf_pkg.sv
// Shared widths, the hardwired-zero index and the storage array type for the
// MIPS general-purpose register file.
package gac_rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_array_t;

endpackage

// File: rtl/gac_rf_read_port.sv
// One read port: 32-to-1 word select built as four 8-to-1 muxes feeding a
// 2-to-1 tree, followed by the WB bypass and r0 zero-forcing.
module gac_rf_read_port
  import gac_rf_pkg::*;
#(
  parameter int DATA_W = gac_rf_pkg::DATA_W,
  parameter int ADDR_W = gac_rf_pkg::ADDR_W
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                  raddr,
  input  logic                               we,
  input  logic [ADDR_W-1:0]                  waddr,
  input  logic [DATA_W-1:0]                  wdata,
  output logic [DATA_W-1:0]                  rdata
);

  // The mux tree is laid out for 32 entries: raddr[2:0] picks within a group
  // of eight, raddr[3] and raddr[4] pick among the four groups.
  logic [DATA_W-1:0] grp [4];
  logic [DATA_W-1:0] mid_lo;
  logic [DATA_W-1:0] mid_hi;
  logic [DATA_W-1:0] sel_word;

  for (genvar g = 0; g < 4; g++) begin : g_grp
    assign grp[g] = regs[{2'(g), raddr[2:0]}];
  end

  assign mid_lo   = raddr[3] ? grp[1] : grp[0];
  assign mid_hi   = raddr[3] ? grp[3] : grp[2];
  assign sel_word = raddr[4] ? mid_hi : mid_lo;

  always_comb begin
    rdata = sel_word;
    if (raddr == REG_ZERO) begin
      rdata = '0;
    end else if (we && (waddr == raddr)) begin
      rdata = wdata;
    end
  end

endmodule

// File: rtl/gac_reg_file.sv
// 32 x 32 MIPS register file: one WB write port, two bypassed read ports,
// optional registered read stage with stall hold, sticky r0-write flag.
module gac_reg_file
  import gac_rf_pkg::*;
#(
  parameter int DATA_W   = gac_rf_pkg::DATA_W,
  parameter int ADDR_W   = gac_rf_pkg::ADDR_W,
  parameter int READ_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              wr_zero_err
);

  localparam int NUM = 2 ** ADDR_W;

  // Entry 0 has no storage; it is tied to zero in the packed view.
  logic [DATA_W-1:0]           mem [1:NUM-1];
  logic [NUM-1:0][DATA_W-1:0]  regs_view;
  logic [DATA_W-1:0]           comb_a;
  logic [DATA_W-1:0]           comb_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM; i++) mem[i] <= '0;
    end else begin
      for (int i = 1; i < NUM; i++) begin
        if (we && (waddr == ADDR_W'(i))) mem[i] <= wdata;
      end
    end
  end

  always_comb begin
    regs_view[0] = '0;
    for (int i = 1; i < NUM; i++) regs_view[i] = mem[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_zero_err <= 1'b0;
    end else if (we && (waddr == REG_ZERO)) begin
      wr_zero_err <= 1'b1;
    end
  end

  gac_rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
    .regs  (regs_view),
    .raddr (raddr_a),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .rdata (comb_a)
  );

  gac_rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
    .regs  (regs_view),
    .raddr (raddr_b),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .rdata (comb_b)
  );

  if (READ_REG != 0) begin : g_read_reg
    // rd_en low is an ID stall: the captured operands are held.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_a <= '0;
        rdata_b <= '0;
      end else if (rd_en) begin
        rdata_a <= comb_a;
        rdata_b <= comb_b;
      end
    end
  end else begin : g_read_comb
    // Reset must also mask the bypass path, which could otherwise show wdata.
    logic unused_rd_en;
    assign unused_rd_en = rd_en;
    assign rdata_a = rst_n ? comb_a : '0;
    assign rdata_b = rst_n ? comb_b : '0;
  end

endmodule

// File: tb/tb_gac_reg_file.sv
// Bench for gac_reg_file: a combinational-read and a registered-read instance
// share stimulus; expected words go into a queue checked by a negedge monitor.
module tb_gac_reg_file;

  typedef struct {
    int          due;
    bit          reg_dut;
    logic [31:0] a;
    logic [31:0] b;
    logic        err;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic        rd_en;
  logic [31:0] rdata_a_c, rdata_b_c, rdata_a_r, rdata_b_r;
  logic        err_c, err_r;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] act_a, act_b;
  logic        act_err;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] held_a = '0;
  logic [31:0] held_b = '0;
  logic        err_m = 1'b0;
  logic        err_next;

  gac_reg_file #(.READ_REG(0)) dut_c (
    .clk (clk), .rst_n (rst_n), .we (we), .waddr (waddr), .wdata (wdata),
    .raddr_a (raddr_a), .raddr_b (raddr_b), .rd_en (rd_en),
    .rdata_a (rdata_a_c), .rdata_b (rdata_b_c), .wr_zero_err (err_c)
  );

  gac_reg_file #(.READ_REG(1)) dut_r (
    .clk (clk), .rst_n (rst_n), .we (we), .waddr (waddr), .wdata (wdata),
    .raddr_a (raddr_a), .raddr_b (raddr_b), .rd_en (rd_en),
    .rdata_a (rdata_a_r), .rdata_b (rdata_b_r), .wr_zero_err (err_r)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int due, input bit r, input logic [31:0] a,
                          input logic [31:0] b, input logic err, input string name);
    exp_t x;
    x.due = due; x.reg_dut = r; x.a = a; x.b = b; x.err = err; x.name = name;
    exp_q.push_back(x);
  endtask

  // One cycle of stimulus. ea/eb are the hand-computed same-cycle read values;
  // the registered instance must show them one edge later when rd_en=1.
  task automatic step(input string name, input logic w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                      input logic re, input logic [31:0] ea, input logic [31:0] eb);
    @(posedge clk); #1;
    we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb; rd_en = re;
    push_exp(cyc, 1'b0, ea, eb, err_m, name);
    if (re) begin
      held_a = ea;
      held_b = eb;
    end
    err_next = err_m | (w && (wa == 5'd0));
    push_exp(cyc + 1, 1'b1, held_a, held_b, err_next, name);
    err_m = err_next;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      act_a   = e.reg_dut ? rdata_a_r : rdata_a_c;
      act_b   = e.reg_dut ? rdata_b_r : rdata_b_c;
      act_err = e.reg_dut ? err_r : err_c;
      total++;
      if (e.due != cyc || act_a !== e.a || act_b !== e.b || act_err !== e.err) begin
        bad++;
        $display("FAIL %s reg=%0d cyc=%0d: got a=%h b=%h err=%b, want a=%h b=%h err=%b (due %0d)",
                 e.name, e.reg_dut, cyc, act_a, act_b, act_err, e.a, e.b, e.err, e.due);
      end
    end
  end

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; rd_en = 1'b1;

    // Reads stay zero during reset even with a bypassing write present
    @(posedge clk); #1;
    we = 1'b1; waddr = 5'd5; wdata = 32'h0000_1234; raddr_a = 5'd5; raddr_b = 5'd5;
    push_exp(cyc, 1'b0, 32'h0, 32'h0, 1'b0, "rst_hold");
    push_exp(cyc, 1'b1, 32'h0, 32'h0, 1'b0, "rst_hold");
    @(posedge clk); #1;
    rst_n = 1'b1; we = 1'b0;

    for (int i = 0; i < 32; i++)
      step("rst_sweep", 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1, 32'h0, 32'h0);

    for (int i = 1; i < 32; i++)
      step("wr_bypass", 1'b1, 5'(i), 32'hA5A5_0000 + 32'(i), 5'(i), 5'd0, 1'b1,
           32'hA5A5_0000 + 32'(i), 32'h0);

    for (int i = 1; i < 32; i++)
      step("readback", 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1,
           32'hA5A5_0000 + 32'(i), (i == 31) ? 32'h0 : 32'hA5A5_001F - 32'(i));

    step("r0_wr", 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
    for (int i = 0; i < 100; i++)
      step("r0_sticky", 1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b1, 32'h0, 32'hA5A5_0005);

    step("byp_setup", 1'b1, 5'd7, 32'h1111_1111, 5'd7, 5'd7, 1'b1, 32'h1111_1111, 32'h1111_1111);
    step("byp_same", 1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd7, 1'b1, 32'h2222_2222, 32'h2222_2222);
    step("byp_after", 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1, 32'h2222_2222, 32'h2222_2222);
    step("byp_a_only", 1'b1, 5'd8, 32'h8888_8888, 5'd8, 5'd9, 1'b1, 32'h8888_8888, 32'hA5A5_0009);

    step("stall_cap", 1'b1, 5'd3, 32'h3, 5'd3, 5'd3, 1'b1, 32'h3, 32'h3);
    step("stall_wr", 1'b1, 5'd3, 32'h4, 5'd3, 5'd3, 1'b0, 32'h4, 32'h4);
    step("stall_hold", 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 32'h4, 32'h4);
    step("stall_rel", 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b1, 32'h4, 32'h4);
    step("stall_post", 1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b1, 32'h4, 32'h0);

    // Asynchronous reset between edges while a write to r9 is pending
    step("r9_wr", 1'b1, 5'd9, 32'hDEAD_BEEF, 5'd9, 5'd9, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    step("r9_rd", 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    while (exp_q.size() > 0 && exp_q[$].due >= cyc) void'(exp_q.pop_back());
    we = 1'b1; waddr = 5'd9; wdata = 32'h1; raddr_a = 5'd9; raddr_b = 5'd9; rd_en = 1'b1;
    #1 rst_n = 1'b0;
    held_a = '0; held_b = '0; err_m = 1'b0;
    push_exp(cyc, 1'b0, 32'h0, 32'h0, 1'b0, "rst_mid");
    push_exp(cyc, 1'b1, 32'h0, 32'h0, 1'b0, "rst_mid");
    @(posedge clk); #1;
    push_exp(cyc, 1'b0, 32'h0, 32'h0, 1'b0, "rst_low");
    push_exp(cyc, 1'b1, 32'h0, 32'h0, 1'b0, "rst_low");
    @(posedge clk); #1;
    rst_n = 1'b1; we = 1'b0;
    step("r9_after", 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 32'h0, 32'h0);
    step("r8_after", 1'b0, 5'd0, 32'h0, 5'd8, 5'd1, 1'b1, 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: %0d expectations never checked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
